pass_gate_arbiter: RTL and testbench
====================================

PASS_GATE_ARBITER -- requirements
Module: pass_gate_arbiter

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters sharing one pass-gate-driven line (2..8).
REQ-002 Parameter: DEAD_CYC, 2, break-before-make cycles with all gates off between owners (1..15).
REQ-003 Parameter: MAX_HOLD, 16, max consecutive grant cycles per ownership (2..255); used only under the macro in REQ-022.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  reset, synchronous and active-high.
REQ-006 Port: req  input  N_REQ  level request; bit i held high while requester i wants the line.
REQ-007 Port: gnt  output  N_REQ  registered one-hot-or-zero grant.
REQ-008 Port: nmos_en  output  N_REQ  NMOS gate controls; 1 = NMOS conducts.
REQ-009 Port: pmos_en_n  output  N_REQ  PMOS gate controls, active-low; 0 = PMOS conducts.
REQ-010 Port: busy  output  1  high in GRANT or DEAD.
REQ-011 Port: timeout_err  output  1  one-cycle pulse on forced release.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANT, DEAD.
REQ-013 IDLE with req != 0 SHALL select the owner round-robin, starting at (last_owner+1) mod N_REQ, and enter GRANT; gnt SHALL be valid the next cycle (1-cycle latency).
REQ-014 IDLE with req == 0 SHALL remain in IDLE with gnt == 0.
REQ-015 GRANT SHALL hold gnt[owner]=1 while req[owner]=1; all other requests SHALL be ignored.
REQ-016 When req[owner] is sampled low in GRANT, the FSM SHALL enter DEAD and gnt SHALL be 0 from the next cycle.
REQ-017 DEAD SHALL last exactly DEAD_CYC cycles and then return to IDLE; gnt SHALL be 0 for at least DEAD_CYC+1 cycles between any two owners.
REQ-018 For every bit i: nmos_en[i] SHALL equal gnt[i], and pmos_en_n[i] SHALL equal ~gnt[i]; no two bits of nmos_en SHALL ever be high together.
REQ-019 last_owner SHALL update only on entry to GRANT.
REQ-020 A requester that drops and re-raises req during DEAD SHALL be arbitrated normally in the following IDLE cycle.

Reset
REQ-021 While rst=1 at a clock edge: state=IDLE, gnt=0, nmos_en=0, pmos_en_n=all ones, busy=0, timeout_err=0, hold counter=0, last_owner=N_REQ-1 (bit 0 wins first); reset mid-GRANT SHALL open all gates at that edge without a DEAD period.

Configuration
REQ-022 Macro PASS_GATE_ARB_TIMEOUT_EN defined: a hold counter SHALL count GRANT cycles; if req[owner] is still high after MAX_HOLD grant cycles, the FSM SHALL enter DEAD, gnt SHALL go 0, and timeout_err SHALL pulse for that one cycle.
REQ-023 With the macro defined, the timed-out requester SHALL be masked from arbitration until it is sampled low once.
REQ-024 Macro undefined: no hold counter or mask SHALL exist, ownership SHALL be unbounded, and timeout_err SHALL be tied to 0 (port retained).

Structure
REQ-025 Package pass_gate_arb_pkg SHALL hold the state enum (IDLE, GRANT, DEAD) and the default values of N_REQ, DEAD_CYC and MAX_HOLD.
REQ-026 The round-robin selection SHALL be a combinational sub-module rr_picker (inputs: req, masked req, last_owner; outputs: one-hot pick, valid).

Verification
REQ-027 Reset release, req=0001 at cycle 0 -> gnt=0001, nmos_en=0001, pmos_en_n=1110 at cycle 1.
REQ-028 Owner 0 drops req at cycle 5 with req=0110 pending, DEAD_CYC=2 -> gnt=0000 at cycles 6-8, gnt=0010 at cycle 9.
REQ-029 req=1111 held, each owner releases after 3 cycles -> grant order 0,1,2,3,0 and never two nmos_en bits high.
REQ-030 rst=1 during GRANT -> gnt=0 and pmos_en_n=1111 at the same edge, and the next grant goes to bit 0.
REQ-031 Macro defined, MAX_HOLD=16, req=0001 held -> gnt[0] for 16 cycles, then timeout_err=1 for one cycle, and no regrant to bit 0 until it drops req.
REQ-032 Macro undefined, req=0001 held for 300 cycles -> gnt=0001 throughout and timeout_err stays 0.

Source files
------------

// File: rtl/pass_gate_arb_pkg.sv
// Shared types and default sizing for the pass-gate line arbiter.
package pass_gate_arb_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, DEAD} state_t;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_DEAD_CYC = 2;
    localparam int DEF_MAX_HOLD = 16;
endpackage

// File: rtl/pass_gate_arbiter_rr_picker.sv
// Combinational round-robin pick: first eligible requester after last_owner.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int OW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] req_m,
    input  logic [OW-1:0]    last_owner,
    output logic [N_REQ-1:0] pick,
    output logic             valid
);
    logic [N_REQ-1:0] eff;
    logic [OW-1:0]    idx;

    // req_m normally already equals req with blocked requesters cleared
    assign eff = req & req_m;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = OW'((int'(last_owner) + k) % N_REQ);
            if (!valid && eff[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/pass_gate_arbiter.sv
// Break-before-make arbiter for one pass-gate-driven shared line.
// Define PASS_GATE_ARB_TIMEOUT_EN to bound ownership to MAX_HOLD cycles.
module pass_gate_arbiter
    import pass_gate_arb_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int DEAD_CYC = DEF_DEAD_CYC,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] nmos_en,
    output logic [N_REQ-1:0] pmos_en_n,
    output logic             busy,
    output logic             timeout_err
);
    localparam int OW = $clog2(N_REQ);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [OW-1:0]    last_q, last_d;
    logic [3:0]       dead_q, dead_d;
    logic [N_REQ-1:0] req_m, pick;
    logic             pick_vld;
    logic [OW-1:0]    pick_idx;

`ifdef PASS_GATE_ARB_TIMEOUT_EN
    logic [7:0]       hold_q, hold_d;
    logic [N_REQ-1:0] mask_q, mask_d;
    logic             tmo_q, tmo_d;
    assign req_m       = req & ~mask_q;
    assign timeout_err = tmo_q;
`else
    assign req_m       = req;
    assign timeout_err = 1'b0;
`endif

    rr_picker #(.N_REQ(N_REQ), .OW(OW)) u_pick (
        .req        (req),
        .req_m      (req_m),
        .last_owner (last_q),
        .pick       (pick),
        .valid      (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (pick[i]) pick_idx = OW'(i);
    end

    // During GRANT last_q is the current owner
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        dead_d  = dead_q;
`ifdef PASS_GATE_ARB_TIMEOUT_EN
        hold_d  = hold_q;
        mask_d  = mask_q & req;
        tmo_d   = 1'b0;
`endif
        case (state_q)
            IDLE: if (pick_vld) begin
                state_d = GRANT;
                gnt_d   = pick;
                last_d  = pick_idx;
`ifdef PASS_GATE_ARB_TIMEOUT_EN
                hold_d  = '0;
`endif
            end
            GRANT: begin
                if (!req[last_q]) begin
                    state_d = DEAD;
                    gnt_d   = '0;
                    dead_d  = '0;
                end
`ifdef PASS_GATE_ARB_TIMEOUT_EN
                else if (hold_q == 8'(MAX_HOLD - 1)) begin
                    state_d        = DEAD;
                    gnt_d          = '0;
                    dead_d         = '0;
                    tmo_d          = 1'b1;
                    mask_d[last_q] = 1'b1;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
`endif
            end
            DEAD: begin
                if (dead_q == 4'(DEAD_CYC - 1)) state_d = IDLE;
                else                            dead_d  = dead_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= OW'(N_REQ - 1);
            dead_q  <= '0;
`ifdef PASS_GATE_ARB_TIMEOUT_EN
            hold_q  <= '0;
            mask_q  <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            dead_q  <= dead_d;
`ifdef PASS_GATE_ARB_TIMEOUT_EN
            hold_q  <= hold_d;
            mask_q  <= mask_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign nmos_en   = gnt_q;
    assign pmos_en_n = ~gnt_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_pass_gate_arbiter.sv
// Randomized bench for pass_gate_arbiter against a cycle-level ownership model.
module tb_pass_gate_arbiter;
    localparam int N  = 4;
    localparam int DC = 2;
    localparam int MH = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt, nmos_en, pmos_en_n;
    logic         busy, timeout_err;

    pass_gate_arbiter #(.N_REQ(N), .DEAD_CYC(DC), .MAX_HOLD(MH)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .gnt         (gnt),
        .nmos_en     (nmos_en),
        .pmos_en_n   (pmos_en_n),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: cur = owner or -1, quiet = dead cycles still to run
    int       cur = -1, quiet = 0, last = N - 1, held = 0;
    bit [3:0] blocked = '0;
    bit       tmo_e = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic model_step(input logic [3:0] r, input logic rs);
        bit found;
        int c;
        if (rs) begin
            cur = -1; quiet = 0; last = N - 1; held = 0; blocked = '0; tmo_e = 1'b0;
            return;
        end
        tmo_e = 1'b0;
        if (cur >= 0) begin
            if (!r[cur[1:0]]) begin
                cur = -1; quiet = DC;
            end
`ifdef PASS_GATE_ARB_TIMEOUT_EN
            else if (held == MH) begin
                blocked[cur[1:0]] = 1'b1;
                cur = -1; quiet = DC; tmo_e = 1'b1;
            end
`endif
            else held++;
        end else if (quiet > 0) begin
            quiet--;
        end else begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                c = (last + k) % N;
                if (!found && r[c[1:0]] && !blocked[c[1:0]]) begin
                    found = 1'b1; cur = c; last = c; held = 1;
                end
            end
        end
        blocked &= r;
    endtask

    task automatic check_all();
        logic [3:0] eg, egn;
        eg  = (cur >= 0) ? (4'b0001 << cur) : 4'b0000;
        egn = ~eg;
        chk("gnt",    32'(gnt),       32'(eg));
        chk("nmos",   32'(nmos_en),   32'(eg));
        chk("pmos_n", 32'(pmos_en_n), 32'(egn));
        chk("busy",   32'(busy),      32'(cur >= 0 || quiet > 0));
        chk("tmo",    32'(timeout_err), 32'(tmo_e));
        chk("onehot", 32'($countones(nmos_en) <= 1), 32'(1));
    endtask

    task automatic tick(input logic [3:0] r, input logic rs);
        req = r;
        rst = rs;
        @(posedge clk);
        model_step(r, rs);
        #1;
        check_all();
    endtask

    initial begin
        logic [3:0] r, prev_g;
        logic [3:0] order[$];
        logic [3:0] exp_order[5];
        int tmo_cnt;

        exp_order[0] = 4'h1; exp_order[1] = 4'h2; exp_order[2] = 4'h4;
        exp_order[3] = 4'h8; exp_order[4] = 4'h1;

        #1;
        tick(4'h0, 1'b1);
        tick(4'h0, 1'b1);
        chk("rst_pmos", 32'(pmos_en_n), 32'hF);

        // first grant one cycle after request, then release into dead time
        tick(4'h1, 1'b0);
        chk("lat_gnt",  32'(gnt),       32'h1);
        chk("lat_pmos", 32'(pmos_en_n), 32'hE);
        for (int i = 0; i < 4; i++) tick(4'h1, 1'b0);
        tick(4'h6, 1'b0);
        chk("dead_c6", 32'(gnt), 32'h0);
        tick(4'h6, 1'b0);
        tick(4'h6, 1'b0);
        chk("dead_c8", 32'(gnt), 32'h0);
        tick(4'h6, 1'b0);
        chk("regnt_c9", 32'(gnt), 32'h2);
        for (int i = 0; i < 6; i++) tick(4'h0, 1'b0);

        // round-robin with every requester holding for 3 grant cycles
        tick(4'h0, 1'b1);
        prev_g = '0;
        for (int t = 0; t < 80 && order.size() < 5; t++) begin
            r = 4'hF;
            if (cur >= 0 && held >= 3) r[cur[1:0]] = 1'b0;
            tick(r, 1'b0);
            if (gnt != 4'h0 && gnt != prev_g) order.push_back(gnt);
            prev_g = gnt;
        end
        chk("rr_cnt", 32'(order.size()), 32'(5));
        for (int i = 0; i < 5 && i < order.size(); i++)
            chk("rr_order", 32'(order[i]), 32'(exp_order[i]));

        // reset mid-grant opens all gates at that edge, bit 0 wins next
        tick(4'hF, 1'b1);
        chk("mid_rst_gnt",  32'(gnt),       32'h0);
        chk("mid_rst_pmos", 32'(pmos_en_n), 32'hF);
        tick(4'hF, 1'b0);
        chk("post_rst", 32'(gnt), 32'h1);

        // long hold on bit 0
        tick(4'h0, 1'b1);
        tmo_cnt = 0;
`ifdef PASS_GATE_ARB_TIMEOUT_EN
        for (int i = 0; i < 60; i++) begin
            tick(4'h1, 1'b0);
            if (timeout_err) tmo_cnt++;
        end
        chk("tmo_pulses", 32'(tmo_cnt), 32'(1));
        chk("masked",     32'(gnt),     32'h0);
        tick(4'h0, 1'b0);
        for (int i = 0; i < 4; i++) tick(4'h1, 1'b0);
        chk("unmasked", 32'(gnt), 32'h1);
`else
        for (int i = 0; i < 300; i++) begin
            tick(4'h1, 1'b0);
            if (timeout_err) tmo_cnt++;
        end
        chk("no_tmo",   32'(tmo_cnt), 32'(0));
        chk("held_300", 32'(gnt),     32'h1);
`endif

        // random traffic, sticky requests, occasional reset
        r = '0;
        for (int t = 0; t < 800; t++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            tick(r, ($urandom_range(0, 149) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
